// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces channels A/B, then turns each
// filtered Gray-code transition into a position step or an illegal-jump error.
module quad_decoder #(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr_pos,
  output logic [CNT_W-1:0] pos,
  output logic             step,
  output logic             up_down,
  output logic             err,
  output logic [3:0]       err_cnt
);

  typedef enum logic {S_PRIME, S_TRACK} state_t;

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN);

  state_t     state, state_nx;
  logic [1:0] sync1, sync2;
  logic [1:0] cand;
  logic [1:0] filt;
  logic [3:0] run_len;
  logic       stable;
  logic       accept, dir_up, dir_dn, illegal;

  // run_len counts consecutive identical synchronized samples, saturating at FILT_LEN
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      run_len <= '0;
    end else begin
      sync1 <= {qa, qb};
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        run_len <= 4'd1;
      end else if (run_len != FILT_MAX) begin
        run_len <= run_len + 4'd1;
      end
    end
  end

  assign stable = (run_len == FILT_MAX);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    dir_up   = 1'b0;
    dir_dn   = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_PRIME: begin
        if (stable) begin
          accept   = 1'b1;
          state_nx = S_TRACK;
        end
      end
      S_TRACK: begin
        if (stable && (cand != filt)) begin
          accept = 1'b1;
          case ({filt, cand})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dir_up  = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dir_dn  = 1'b1;
            default:                                illegal = 1'b1;
          endcase
        end
      end
      default: state_nx = S_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_PRIME;
      filt    <= '0;
      pos     <= '0;
      step    <= 1'b0;
      up_down <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      step  <= dir_up | dir_dn;
      err   <= illegal;
      if (accept)
        filt <= cand;
      if (dir_up | dir_dn)
        up_down <= dir_dn;
      if (illegal && (err_cnt != 4'hF))
        err_cnt <= err_cnt + 4'd1;
      // clear wins over a same-cycle step; direction/step still reflect it
      if (clr_pos)
        pos <= '0;
      else if (dir_up)
        pos <= pos + CNT_W'(1);
      else if (dir_dn)
        pos <= pos - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with a sample-history reference model
// compared against the outputs every cycle.
module tb_quad_decoder;

  localparam int CNT_W = 8;
  localparam int F     = 3;
  localparam int HMAX  = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             qa = 1'b1, qb = 1'b1;
  logic             clr_pos = 1'b0;
  logic [CNT_W-1:0] pos;
  logic             step, up_down, err;
  logic [3:0]       err_cnt;

  quad_decoder #(.CNT_W(CNT_W), .FILT_LEN(F)) dut (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .clr_pos(clr_pos),
    .pos(pos), .step(step), .up_down(up_down), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a level is accepted when the raw samples taken
  // FILT_LEN+2 .. 3 edges ago (all after reset) agree and differ from the last level.
  logic [1:0]       hist [0:HMAX-1];
  int               cyc = -1;
  int               last_rst = -1;
  logic [CNT_W-1:0] m_pos = '0;
  logic             m_step = 1'b0, m_err = 1'b0, m_ud = 1'b0, m_primed = 1'b0;
  logic [1:0]       m_f = '0;
  int               m_ec = 0;

  function automatic int ring_idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [1:0] lvl;
    logic       same;
    int         d;
    cyc++;
    hist[cyc] = reset ? 2'b00 : {qa, qb};
    m_step = 1'b0;
    m_err  = 1'b0;
    if (reset) begin
      last_rst = cyc;
      m_pos = '0; m_ud = 1'b0; m_ec = 0; m_primed = 1'b0; m_f = '0;
    end else begin
      if ((cyc - F - 2 >= 0) && (cyc - F > last_rst)) begin
        lvl  = hist[cyc-3];
        same = 1'b1;
        for (int i = cyc - F - 2; i <= cyc - 3; i++)
          if (hist[i] != lvl) same = 1'b0;
        if (same && (!m_primed || lvl != m_f)) begin
          if (m_primed) begin
            d = (ring_idx(lvl) - ring_idx(m_f) + 4) % 4;
            if (d == 1)      begin m_pos = m_pos + 1; m_ud = 1'b0; m_step = 1'b1; end
            else if (d == 3) begin m_pos = m_pos - 1; m_ud = 1'b1; m_step = 1'b1; end
            else             begin m_err = 1'b1; if (m_ec < 15) m_ec++; end
          end
          m_primed = 1'b1;
          m_f = lvl;
        end
      end
      if (clr_pos) m_pos = '0;
    end
  end

  int step_seen = 0, err_seen = 0, last_step_cyc = -100;

  always @(negedge clk) begin
    chk("pos", int'(pos), int'(m_pos));
    chk("step", int'(step), int'(m_step));
    chk("err", int'(err), int'(m_err));
    chk("up_down", int'(up_down), int'(m_ud));
    chk("err_cnt", int'(err_cnt), m_ec);
    chk("step_err_excl", int'(step & err), 0);
    if (step) begin step_seen++; last_step_cyc = cyc; end
    if (err) err_seen++;
  end

  int t0;

  task automatic set_ab(input logic [1:0] v);
    @(posedge clk); #1;
    {qa, qb} = v;
    t0 = cyc + 1;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_pos = 1'b1;
    @(posedge clk); #1 clr_pos = 1'b0;
  endtask

  initial begin
    logic [1:0] fwd [4];
    int s0;
    fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;

    // reset held with 11 on the inputs, then priming on release
    hold(3);
    chk("rst_pos", int'(pos), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    reset = 1'b0;
    hold(10);
    chk("prime_steps", step_seen, 0);
    chk("prime_errs", err_seen, 0);
    chk("prime_pos", int'(pos), 0);
    chk("prime_model", int'(m_primed), 1);

    // partial level discarded by a reset, no pulse afterwards
    set_ab(2'b01);
    hold(2);
    reset = 1'b1; {qa, qb} = 2'b00;
    hold(3);
    reset = 1'b0;
    hold(12);
    chk("mid_rst_steps", step_seen, 0);
    chk("mid_rst_errs", err_seen, 0);

    // four forward cycles, each step 5 clk after the level is first sampled
    s0 = step_seen;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        set_ab(fwd[k]);
        hold(10);
        chk("fwd_latency", last_step_cyc - t0, F + 2);
      end
    chk("fwd_steps", step_seen - s0, 16);
    chk("fwd_pos", int'(pos), 16);
    chk("fwd_dir", int'(up_down), 0);

    // wrap below zero and back
    pulse_clr();
    hold(1);
    chk("clr_pos", int'(pos), 0);
    set_ab(2'b10);
    hold(10);
    chk("wrap_dn_pos", int'(pos), 255);
    chk("wrap_dn_dir", int'(up_down), 1);
    set_ab(2'b00);
    hold(10);
    chk("wrap_up_pos", int'(pos), 0);
    chk("wrap_up_dir", int'(up_down), 0);

    // 2-clk glitch on qa is filtered out
    s0 = step_seen;
    set_ab(2'b10);
    @(posedge clk); @(posedge clk); #1 {qa, qb} = 2'b00;
    hold(10);
    chk("glitch_steps", step_seen - s0, 0);
    chk("glitch_pos", int'(pos), 0);
    chk("glitch_level", int'(m_f), 0);

    // 17 illegal jumps saturate err_cnt
    for (int i = 0; i < 17; i++) begin
      set_ab((i % 2 == 0) ? 2'b11 : 2'b00);
      hold(10);
    end
    chk("jump_errs", err_seen, 17);
    chk("jump_err_cnt", int'(err_cnt), 15);
    chk("jump_pos", int'(pos), 0);

    // clear coinciding with an up step from pos=7
    pulse_clr();
    for (int k = 0; k < 7; k++) begin
      set_ab(fwd[(k + 2) % 4]);
      hold(10);
    end
    chk("pre_clr_pos", int'(pos), 7);
    set_ab(2'b11);
    repeat (5) @(posedge clk);
    #1 clr_pos = 1'b1;
    @(posedge clk); #1 clr_pos = 1'b0;
    chk("clr_step_pos", int'(pos), 0);
    chk("clr_step_step", int'(step), 1);
    chk("clr_step_dir", int'(up_down), 0);
    chk("clr_keeps_err_cnt", int'(err_cnt), 15);
    hold(10);
    set_ab(2'b10);
    hold(10);
    chk("post_clr_pos", int'(pos), 1);

    // outputs stay in reset state while inputs toggle under reset
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 {qa, qb} = 2'(i);
    end
    hold(1);
    chk("rst_hold_pos", int'(pos), 0);
    chk("rst_hold_err_cnt", int'(err_cnt), 0);
    reset = 1'b0;
    hold(12);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CNT_W, default 8, width of position count pos.
REQ-002 Parameter FILT_LEN, default 3, number of consecutive identical synchronized samples required to accept a new input level; legal range 1..15.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 qa  input  1  quadrature channel A, asynchronous to clk.
REQ-006 qb  input  1  quadrature channel B, asynchronous to clk.
REQ-007 clr_pos  input  1  synchronous clear of pos, single-cycle strobe.
REQ-008 pos  output  CNT_W  signed-agnostic position count (modulo 2^CNT_W).
REQ-009 step  output  1  one-cycle pulse per accepted legal transition.
REQ-010 up_down  output  1  direction of last accepted step: 0 = up, 1 = down; holds between steps.
REQ-011 err  output  1  one-cycle pulse on illegal transition (both channels changed).
REQ-012 err_cnt  output  4  count of illegal transitions, saturating at 15.

Function
REQ-013 qa/qb each pass through a 2-flop synchronizer before any other use.
REQ-014 Filter: filtered pair {fa,fb} takes the synchronized pair only when that pair has been identical for FILT_LEN consecutive clk samples and differs from {fa,fb}; shorter pulses are discarded with no output effect.
REQ-015 Decode on each filtered change, state {fa,fb} old->new: 00->01, 01->11, 11->10, 10->00 = up; reverse of each = down.
REQ-016 Up: pos <= pos + 1, up_down <= 0, step <= 1 for one cycle.
REQ-017 Down: pos <= pos - 1, up_down <= 1, step <= 1 for one cycle.
REQ-018 pos wraps modulo 2^CNT_W: all-ones + 1 -> 0; 0 - 1 -> all-ones; no flag on wrap.
REQ-019 Illegal change (00<->11, 01<->10): err <= 1 for one cycle, err_cnt increments unless already 15, pos/up_down/step unchanged.
REQ-020 Latency: first clk edge sampling a new qa/qb level is t0; with input held stable, step/err rise and pos updates at edge t0+FILT_LEN+2.
REQ-021 clr_pos has priority over a same-cycle step: pos <= 0, step and up_down still update as for the transition.
REQ-022 clr_pos does not affect err_cnt; err_cnt clears only on reset.
REQ-023 At most one accepted transition per clk cycle; step and err are never both high.
REQ-024 Priming: first filtered pair accepted after reset is loaded into {fa,fb} without step, err, or pos change.

Reset
REQ-025 On reset: pos = 0, up_down = 0, step = 0, err = 0, err_cnt = 0, synchronizer and filter state cleared, priming flag cleared.
REQ-026 Reset asserted mid-sequence discards any partially filtered level; no step/err pulse in the cycle after reset deasserts.
REQ-027 Outputs hold reset values while reset is high regardless of qa/qb.

Verification
REQ-028 Reset release with qa=1,qb=1 held -> priming occurs, no step/err, pos stays 0.
REQ-029 Four forward cycles 00->01->11->10->00 (each level held 10 clk), FILT_LEN=3 -> 16 step pulses, up_down=0, pos=16, each step exactly 5 clk after its level change.
REQ-030 pos=0, one reverse transition 00->10 -> pos=255 (CNT_W=8), up_down=1; then forward 10->00 -> pos=0, up_down=0.
REQ-031 2-clk glitch on qa with FILT_LEN=3 -> no step, pos and {fa,fb} unchanged.
REQ-032 Jump 00->11 repeated 17 times (interleaved with 11->00) -> 17 err pulses, err_cnt=15 saturated, pos unchanged.
REQ-033 clr_pos asserted in same cycle as an up step with pos=7 -> pos=0, step=1, up_down=0; next up step -> pos=1.
